// File: rtl/shift_ctrl_pkg.sv
// Shared types and default sizes for the shift-register controller.
package shift_ctrl_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shift_cnt.sv
// Loadable down-counter tracking the shifts remaining in a transaction.
module shift_cnt
    import shift_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count = r_count;
    assign last  = (r_count == CNT_W'(1));

endmodule

// File: rtl/shift_reg_ctrl.sv
// Load/shift controller for an external shift register (q fed back).
// Optional SHIFT_REG_CTRL_ROTATE_EN adds port rot: rotate right via q[0].
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] nshift,
    input  logic             ser_in,
`ifdef SHIFT_REG_CTRL_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] R,
    output logic             L,
    output logic             E,
    output logic             W,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam logic [CNT_W-1:0] LP_MAX_CNT = CNT_W'(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] r_dout;
    logic             r_done;
    logic             w_l;
    logic             w_e;
    logic             w_busy;
    logic             w_accept;
    logic             w_src;
    logic             w_last;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_nshift_clamped;

    assign w_accept         = (r_state == S_IDLE) && start;
    assign w_nshift_clamped = (nshift > LP_MAX_CNT) ? LP_MAX_CNT : nshift;

    shift_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (w_accept),
        .load_val (w_nshift_clamped),
        .dec      (w_e),
        .count    (w_count),
        .last     (w_last)
    );

`ifdef SHIFT_REG_CTRL_ROTATE_EN
    logic r_rot;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rot <= 1'b0;
        end else if (w_accept) begin
            r_rot <= rot;
        end
    end

    assign w_src = r_rot ? q[0] : ser_in;
`else
    assign w_src = ser_in;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_load_val <= '0;
            r_dout     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            // done is registered so it lands in the IDLE cycle after DONE
            r_done  <= (r_state == S_DONE);
            if (w_accept) begin
                r_load_val <= din;
            end
            if (r_state == S_DONE) begin
                r_dout <= q;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_l    = 1'b0;
        w_e    = 1'b0;
        w_busy = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_l    = 1'b1;
                w_next = (w_count != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                w_e = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign R    = r_load_val;
    assign L    = w_l;
    assign E    = w_e;
    assign W    = w_e ? w_src : 1'b0;
    assign busy = w_busy;
    assign done = r_done;
    assign dout = r_dout;

endmodule

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the shift-register data width (matches the 8-bit shift register).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the shift-count width.
REQ-003 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  transaction request, sampled only in IDLE.
REQ-006 The block SHALL have port din  input  WIDTH  parallel word to load.
REQ-007 The block SHALL have port nshift  input  CNT_W  number of shifts requested (0..WIDTH).
REQ-008 The block SHALL have port ser_in  input  1  serial bit fed to register MSB during shifts.
REQ-009 The block SHALL have port q  input  WIDTH  current shift-register contents.
REQ-010 The block SHALL have port R  output  WIDTH  parallel load value to shift register.
REQ-011 The block SHALL have ports L, E, W  output  1 each  load enable, shift enable, serial MSB input of the shift register.
REQ-012 The block SHALL have ports busy, done  output  1 each  transaction in progress; one-cycle completion pulse.
REQ-013 The block SHALL have port dout  output  WIDTH  register contents captured at completion.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-015 In IDLE with start=1, the block SHALL latch din into R and min(nshift, WIDTH) into a down-counter, then go to LOAD.
REQ-016 LOAD SHALL assert L for exactly one cycle, then go to SHIFT if count>0, else DONE.
REQ-017 SHIFT SHALL assert E every cycle, decrement the count per cycle, and go to DONE after exactly count cycles.
REQ-018 W SHALL equal the selected serial source while E=1, and 0 otherwise.
REQ-019 In DONE, the block SHALL register dout<=q and done<=1, then return to IDLE.
REQ-020 Latency: done SHALL be high exactly one cycle, n+2 clocks after the edge accepting start (n = clamped count).
REQ-021 busy SHALL be high in LOAD, SHIFT and DONE, and low in IDLE.
REQ-022 start SHALL be ignored while busy.
REQ-023 start SHALL be accepted in the IDLE cycle in which done is high.
REQ-024 L and E SHALL never be high in the same cycle.
REQ-025 nshift values above WIDTH SHALL be clamped to WIDTH.
REQ-026 dout SHALL hold its value until the next completion.

Reset
REQ-027 reset=1 SHALL force IDLE and set L=E=W=0, done=0, busy=0, R=0, dout=0 and count=0, in any state, including mid-SHIFT.
REQ-028 reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 With macro SHIFT_REG_CTRL_ROTATE_EN defined, the block SHALL add input port rot (1 bit), latched with start; when latched rot=1, the W source SHALL be q[0] (rotate right), otherwise ser_in.
REQ-030 Without SHIFT_REG_CTRL_ROTATE_EN, port rot SHALL be absent and the W source SHALL always be ser_in.

Structure
REQ-031 A shared package shift_ctrl_pkg SHALL hold the state enum type, the default WIDTH/CNT_W constants, and the state encodings.
REQ-032 The down-counter SHALL be the natural sub-module, named shift_cnt; the FSM, muxing and capture logic stay in shift_reg_ctrl.
REQ-033 The testbench SHALL instantiate shift_reg_ctrl driving the 8-bit shift register, with q fed back.

Verification
REQ-034 din=0xA5, nshift=0, start pulse -> one L cycle, no E, done after 2 clocks, dout=0xA5.
REQ-035 din=0x00, nshift=8, ser_in sequence 1,0,1,1,0,0,1,0 -> 8 E cycles, dout=0x4D.
REQ-036 din=0xFF, nshift=3, ser_in=0 -> dout=0x1F; start re-asserted during SHIFT ignored; busy high for 5 cycles.
REQ-037 nshift=12 -> clamped, exactly 8 E cycles; reset asserted at 4th E cycle -> IDLE next cycle, done never pulses, dout=0x00.
REQ-038 With SHIFT_REG_CTRL_ROTATE_EN defined: din=0x81, nshift=1, rot=1 -> dout=0xC0.
REQ-039 All scenarios: assertion that L&E is never 1, and done is never high two consecutive cycles.
